usb_tx_buffer: RTL and testbench

USB_TX_BUFFER -- requirements
Module: usb_tx_buffer

---
 rtl/usb_pkg.sv | 11 +
 rtl/usb_tx_buffer_if.sv | 28 ++
 rtl/usb_tx_buf_mem.sv | 25 ++
 rtl/usb_tx_buffer.sv | 80 ++++++++
 tb/tb_usb_tx_buffer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared widths, depth and data types for the USB transmit path.
package usb_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned SIZE_W = 7;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [SIZE_W-1:0] size_t;

endpackage

// File: rtl/usb_tx_buffer_if.sv
// Host-side write / usb_tx-side read bundle for the transmit byte buffer.
interface usb_tx_buffer_if;
    import usb_pkg::*;

    logic  store_tx_data;
    byte_t tx_data;
    logic  flush;
    logic  get_tx_packet;
    byte_t tx_packet_data;
    size_t tx_packet_data_size;
    logic  buffer_full;
    logic  buffer_empty;
    logic  overflow_err;
    logic  underflow_err;

    modport master (
        output store_tx_data, tx_data, flush, get_tx_packet,
        input  tx_packet_data, tx_packet_data_size, buffer_full, buffer_empty,
               overflow_err, underflow_err
    );

    modport slave (
        input  store_tx_data, tx_data, flush, get_tx_packet,
        output tx_packet_data, tx_packet_data_size, buffer_full, buffer_empty,
               overflow_err, underflow_err
    );

endinterface

// File: rtl/usb_tx_buf_mem.sv
// DEPTH x 8 register file: synchronous write, asynchronous read, never reset.
module usb_tx_buf_mem
    import usb_pkg::*;
#(
    parameter int unsigned DEPTH = usb_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  byte_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output byte_t                    rdata
);

    byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/usb_tx_buffer.sv
// Circular show-ahead byte FIFO between the protocol controller and usb_tx,
// with occupancy reporting and sticky overflow/underflow flags.
module usb_tx_buffer
    import usb_pkg::*;
#(
    parameter int unsigned DEPTH = usb_pkg::DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    usb_tx_buffer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    size_t            count;
    logic             overflow_q;
    logic             underflow_q;

    logic  full_c;
    logic  empty_c;
    logic  wr_acc_c;
    logic  rd_acc_c;
    logic  mem_we_c;
    byte_t mem_rd_c;

    assign full_c   = (count == SIZE_W'(DEPTH));
    assign empty_c  = (count == '0);
    assign rd_acc_c = bus.get_tx_packet && !empty_c;
    // A read in the same cycle frees the slot, so a full buffer still takes the write.
    assign wr_acc_c = bus.store_tx_data && (!full_c || bus.get_tx_packet);
    assign mem_we_c = wr_acc_c && !rst && !bus.flush;

    usb_tx_buf_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (wr_ptr),
        .wdata (bus.tx_data),
        .raddr (rd_ptr),
        .rdata (mem_rd_c)
    );

    // Pointer, occupancy and sticky error state; rst beats flush beats traffic.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count <= count + SIZE_W'(1);
                2'b01:   count <= count - SIZE_W'(1);
                default: count <= count;
            endcase
            if (bus.store_tx_data && full_c && !bus.get_tx_packet) begin
                overflow_q <= 1'b1;
            end
            if (bus.get_tx_packet && empty_c) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.tx_packet_data      = empty_c ? '0 : mem_rd_c;
    assign bus.tx_packet_data_size = count;
    assign bus.buffer_full         = full_c;
    assign bus.buffer_empty        = empty_c;
    assign bus.overflow_err        = overflow_q;
    assign bus.underflow_err       = underflow_q;

endmodule

// File: tb/tb_usb_tx_buffer.sv
// Bench for usb_tx_buffer: directed table, corner sequences and random traffic vs a queue model.
module tb_usb_tx_buffer;
    import usb_pkg::*;

    localparam int unsigned D = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_tx_buffer_if bus ();

    usb_tx_buffer #(.DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain byte queue plus two sticky flags.
    byte_t q[$];
    bit    m_ovf;
    bit    m_udf;

    typedef struct {
        bit    r;
        bit    s;
        bit    f;
        bit    g;
        byte_t d;
        int    size;
        byte_t head;
        bit    ovf;
        bit    udf;
    } vec_t;

    vec_t tab[13];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit f, input bit g, input byte_t d);
        bit was_full;
        bit was_empty;
        if (r || f) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            was_full  = (q.size() == D);
            was_empty = (q.size() == 0);
            if (g && was_empty) m_udf = 1'b1;
            if (s && was_full && !g) m_ovf = 1'b1;
            if (g && !was_empty) void'(q.pop_front());
            if (s && (!was_full || g)) q.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        byte_t head;
        head = (q.size() != 0) ? q[0] : 8'h00;
        cmp({tag, ".size"},  32'(bus.tx_packet_data_size), 32'(q.size()));
        cmp({tag, ".head"},  32'(bus.tx_packet_data),      32'(head));
        cmp({tag, ".full"},  32'(bus.buffer_full),         32'(q.size() == D));
        cmp({tag, ".empty"}, 32'(bus.buffer_empty),        32'(q.size() == 0));
        cmp({tag, ".ovf"},   32'(bus.overflow_err),        32'(m_ovf));
        cmp({tag, ".udf"},   32'(bus.underflow_err),       32'(m_udf));
    endtask

    task automatic cycle(input string tag, input bit r, input bit s, input bit f, input bit g,
                         input byte_t d);
        rst               = r;
        bus.store_tx_data = s;
        bus.tx_data       = d;
        bus.flush         = f;
        bus.get_tx_packet = g;
        @(posedge clk);
        model_step(r, s, f, g, d);
        #1;
        check_model(tag);
    endtask

    initial begin
        int ps;
        int pg;
        string tag;

        rst = 1'b1;
        bus.store_tx_data = 1'b0;
        bus.tx_data       = 8'h00;
        bus.flush         = 1'b0;
        bus.get_tx_packet = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;

        //          r  s  f  g  d      size head   ovf udf
        tab[0]  = '{1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0};
        tab[1]  = '{0, 1, 0, 0, 8'hA5, 1, 8'hA5, 0, 0};
        tab[2]  = '{0, 1, 0, 0, 8'h11, 2, 8'hA5, 0, 0};
        tab[3]  = '{0, 0, 0, 1, 8'h00, 1, 8'h11, 0, 0};
        tab[4]  = '{0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0};
        tab[5]  = '{0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 1};
        tab[6]  = '{0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
        tab[7]  = '{0, 1, 0, 1, 8'h3C, 1, 8'h3C, 0, 1};
        tab[8]  = '{0, 1, 0, 1, 8'h77, 1, 8'h77, 0, 1};
        tab[9]  = '{0, 1, 1, 0, 8'h99, 0, 8'h00, 0, 0};
        tab[10] = '{0, 1, 0, 0, 8'h42, 1, 8'h42, 0, 0};
        tab[11] = '{1, 1, 0, 1, 8'h5A, 0, 8'h00, 0, 0};
        tab[12] = '{0, 1, 0, 0, 8'h5A, 1, 8'h5A, 0, 0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            tag = $sformatf("tab%0d", i);
            cycle(tag, tab[i].r, tab[i].s, tab[i].f, tab[i].g, tab[i].d);
            cmp({tag, ".vsize"}, 32'(bus.tx_packet_data_size), 32'(tab[i].size));
            cmp({tag, ".vhead"}, 32'(bus.tx_packet_data),      32'(tab[i].head));
            cmp({tag, ".vovf"},  32'(bus.overflow_err),        32'(tab[i].ovf));
            cmp({tag, ".vudf"},  32'(bus.underflow_err),       32'(tab[i].udf));
        end

        // Fill to capacity, then overflow.
        cycle("fillA.flush", 0, 0, 1, 0, 8'h00);
        for (int i = 0; i < D; i++) cycle("fillA", 0, 1, 0, 0, byte_t'(i));
        cmp("fillA.full", 32'(bus.buffer_full), 32'd1);
        cmp("fillA.size", 32'(bus.tx_packet_data_size), 32'd64);
        cycle("ovf", 0, 1, 0, 0, 8'hEE);
        cmp("ovf.flag", 32'(bus.overflow_err), 32'd1);
        cmp("ovf.head", 32'(bus.tx_packet_data), 32'h00);
        cycle("ovf.read", 0, 0, 0, 1, 8'h00);
        cmp("ovf.next", 32'(bus.tx_packet_data), 32'h01);

        // Simultaneous write+read while full, then drain across the wrap.
        cycle("fillB.flush", 0, 0, 1, 0, 8'h00);
        for (int i = 0; i < D; i++) cycle("fillB", 0, 1, 0, 0, byte_t'(i));
        cycle("fullrw", 0, 1, 0, 1, 8'hFF);
        cmp("fullrw.size", 32'(bus.tx_packet_data_size), 32'd64);
        cmp("fullrw.ovf",  32'(bus.overflow_err), 32'd0);
        for (int i = 0; i < D; i++) begin
            if (i == D - 1) cmp("wrap.last", 32'(bus.tx_packet_data), 32'hFF);
            cycle("drain", 0, 0, 0, 1, 8'h00);
        end
        cmp("drain.empty", 32'(bus.buffer_empty), 32'd1);

        // Flush beats a concurrent write.
        for (int i = 0; i < 10; i++) cycle("flw", 0, 1, 0, 0, byte_t'(8'h20 + i));
        cycle("flush_st", 0, 1, 1, 0, 8'hAB);
        cmp("flush_st.size",  32'(bus.tx_packet_data_size), 32'd0);
        cmp("flush_st.empty", 32'(bus.buffer_empty), 32'd1);

        // Reset mid-packet beats a concurrent read.
        for (int i = 0; i < 5; i++) cycle("rsw", 0, 1, 0, 0, byte_t'(8'h30 + i));
        cycle("rst_rd", 1, 0, 0, 1, 8'h00);
        cmp("rst_rd.size",  32'(bus.tx_packet_data_size), 32'd0);
        cmp("rst_rd.empty", 32'(bus.buffer_empty), 32'd1);
        cycle("post_rst", 0, 1, 0, 0, 8'hC3);
        cmp("post_rst.head", 32'(bus.tx_packet_data), 32'hC3);

        // Random traffic with drifting write/read bias to reach full and empty.
        ps = 50;
        pg = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ps = int'($urandom_range(90, 10));
                pg = int'($urandom_range(90, 10));
            end
            cycle("rand",
                  ($urandom_range(499, 0) == 0),
                  (int'($urandom_range(99, 0)) < ps),
                  ($urandom_range(149, 0) == 0),
                  (int'($urandom_range(99, 0)) < pg),
                  byte_t'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
